// File: rtl/number_entry_pkg.sv
// number_entry_pkg: scan-code constants, digit decode table and FSM state type.
// Revision: 1.0
`default_nettype none

package number_entry_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  // Top-row digit make codes (set 2).
  localparam logic [7:0] SC_D0 = 8'h45;
  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;
  localparam logic [7:0] SC_D8 = 8'h3E;
  localparam logic [7:0] SC_D9 = 8'h46;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CONVERT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } digit_t;

  function automatic digit_t decode_digit(input logic [7:0] code);
    digit_t d;
    d.valid = 1'b1;
    d.value = 4'd0;
    case (code)
      SC_D0:   d.value = 4'd0;
      SC_D1:   d.value = 4'd1;
      SC_D2:   d.value = 4'd2;
      SC_D3:   d.value = 4'd3;
      SC_D4:   d.value = 4'd4;
      SC_D5:   d.value = 4'd5;
      SC_D6:   d.value = 4'd6;
      SC_D7:   d.value = 4'd7;
      SC_D8:   d.value = 4'd8;
      SC_D9:   d.value = 4'd9;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/number_entry_ctrl_if.sv
// number_entry_ctrl_if: scan-byte input, operand handshake and entry status bundle.
// Revision: 1.0
`default_nettype none

interface number_entry_ctrl_if #(
  parameter int MAX_DIGITS = 4,
  parameter int NUM_W      = 16
);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic [7:0]              scan_code;
  logic                    scan_valid;
  logic                    num_ready;
  logic [NUM_W-1:0]        number;
  logic                    num_valid;
  logic [4*MAX_DIGITS-1:0] digits_bcd;
  logic [CNT_W-1:0]        digit_count;
  logic                    busy;
  logic                    overflow;

  modport master (
    output scan_code, scan_valid, num_ready,
    input  number, num_valid, digits_bcd, digit_count, busy, overflow
  );

  modport slave (
    input  scan_code, scan_valid, num_ready,
    output number, num_valid, digits_bcd, digit_count, busy, overflow
  );

endinterface

`default_nettype wire

// File: rtl/ps2_key_event.sv
// ps2_key_event: folds F0/E0 prefixes into single-cycle key events.
// Revision: 1.0
`default_nettype none

module ps2_key_event
  import number_entry_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk
);

  logic brk_pend;
  logic ext_pend;
  logic is_prefix;

  assign is_prefix = (scan_code == SC_BREAK) || (scan_code == SC_EXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_pend <= 1'b0;
      ext_pend <= 1'b0;
    end else if (scan_valid) begin
      if (scan_code == SC_BREAK) begin
        brk_pend <= 1'b1;
      end else if (scan_code == SC_EXT) begin
        ext_pend <= 1'b1;
      end else begin
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
      end
    end
  end

  // The event is emitted in the same cycle as its final byte; flags clear behind it.
  assign key_valid = scan_valid && !is_prefix;
  assign key_code  = scan_code;
  assign key_ext   = ext_pend;
  assign key_brk   = brk_pend;

endmodule

`default_nettype wire

// File: rtl/number_entry_ctrl.sv
// number_entry_ctrl: buffers PS/2 digit keys as BCD and converts to binary on Enter.
// Revision: 1.0
`default_nettype none

module number_entry_ctrl
  import number_entry_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int NUM_W      = 16
) (
  input logic                CLOCK_50,
  input logic                reset,
  number_entry_ctrl_if.slave bus
);

  localparam int                DW      = 4 * MAX_DIGITS;
  localparam int                CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;

  state_t           state, state_nx;
  logic [DW-1:0]    digits, digits_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [CNT_W-1:0] idx, idx_nx;
  logic [NUM_W-1:0] acc, acc_nx;
  logic [NUM_W-1:0] number_q, number_nx;
  logic             num_valid_q, num_valid_nx;
  logic             overflow_q, overflow_nx;

  logic             make;
  digit_t           dig;
  logic             is_digit;
  logic             is_enter;
  logic             is_bksp;
  logic             is_esc;
  logic [DW-1:0]    sel;
  logic [3:0]       nibble;
  logic [NUM_W-1:0] acc_step;

  ps2_key_event u_key_event (
    .clk        (CLOCK_50),
    .rst        (reset),
    .scan_code  (bus.scan_code),
    .scan_valid (bus.scan_valid),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_brk    (key_brk)
  );

  assign make     = key_valid && !key_brk;
  assign dig      = decode_digit(key_code);
  assign is_digit = make && !key_ext && dig.valid;
  assign is_enter = make && (key_code == SC_ENTER);
  assign is_bksp  = make && (key_code == SC_BKSP);
  assign is_esc   = make && (key_code == SC_ESC);

  // Horner step, most significant digit first; x10 as x8 + x2.
  assign sel      = digits >> {idx, 2'b00};
  assign nibble   = sel[3:0];
  assign acc_step = (acc << 3) + (acc << 1) + NUM_W'(nibble);

  always_comb begin
    state_nx     = state;
    digits_nx    = digits;
    count_nx     = count;
    idx_nx       = idx;
    acc_nx       = acc;
    number_nx    = number_q;
    num_valid_nx = num_valid_q;
    overflow_nx  = 1'b0;

    case (state)
      ENTRY: begin
        if (is_digit) begin
          if (count < MAX_CNT) begin
            digits_nx = (digits << 4) | DW'(dig.value);
            count_nx  = count + CNT_W'(1);
          end else begin
            overflow_nx = 1'b1;
          end
        end else if (is_bksp) begin
          if (count != '0) begin
            digits_nx = digits >> 4;
            count_nx  = count - CNT_W'(1);
          end
        end else if (is_esc) begin
          digits_nx = '0;
          count_nx  = '0;
        end else if (is_enter && (count != '0)) begin
          acc_nx   = '0;
          idx_nx   = count - CNT_W'(1);
          state_nx = CONVERT;
        end
      end

      CONVERT: begin
        acc_nx = acc_step;
        if (idx == '0) begin
          number_nx    = acc_step;
          num_valid_nx = 1'b1;
          state_nx     = HOLD;
        end else begin
          idx_nx = idx - CNT_W'(1);
        end
      end

      HOLD: begin
        if (bus.num_ready && num_valid_q) begin
          num_valid_nx = 1'b0;
          digits_nx    = '0;
          count_nx     = '0;
          state_nx     = ENTRY;
        end
      end

      default: begin
        state_nx = ENTRY;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= ENTRY;
      digits      <= '0;
      count       <= '0;
      idx         <= '0;
      acc         <= '0;
      number_q    <= '0;
      num_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state       <= state_nx;
      digits      <= digits_nx;
      count       <= count_nx;
      idx         <= idx_nx;
      acc         <= acc_nx;
      number_q    <= number_nx;
      num_valid_q <= num_valid_nx;
      overflow_q  <= overflow_nx;
    end
  end

  assign bus.number      = number_q;
  assign bus.num_valid   = num_valid_q;
  assign bus.digits_bcd  = digits;
  assign bus.digit_count = count;
  assign bus.busy        = (state != ENTRY);
  assign bus.overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_number_entry_ctrl.sv
// tb_number_entry_ctrl: directed scan-byte sequences with a queue of expected operands.
// Revision: 1.0
`default_nettype none

module tb_number_entry_ctrl;

  logic CLOCK_50;
  logic reset;
  int   errors;
  int   checks;
  int   sb[$];

  number_entry_ctrl_if #(.MAX_DIGITS(4), .NUM_W(16)) bus ();

  number_entry_ctrl #(.MAX_DIGITS(4), .NUM_W(16)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge after the byte has been sampled.
  task automatic send(input logic [7:0] b);
    @(negedge CLOCK_50);
    bus.scan_code  = b;
    bus.scan_valid = 1'b1;
    @(negedge CLOCK_50);
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
  endtask

  // Call straight after Enter; checks latency, pops the scoreboard, then accepts.
  task automatic expect_number(input string tag, input int ndig);
    int cyc;
    int exp;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    while (!seen && cyc < 20) begin
      @(negedge CLOCK_50);
      cyc++;
      if (bus.num_valid === 1'b1) seen = 1'b1;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(ndig));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_number"}, 32'(bus.number), 32'(exp));
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      chk({tag, "_hold_valid"}, 32'(bus.num_valid), 32'd1);
      chk({tag, "_hold_number"}, 32'(bus.number), 32'(exp));
      bus.num_ready = 1'b1;
      @(negedge CLOCK_50);
      bus.num_ready = 1'b0;
      chk({tag, "_acc_valid"}, 32'(bus.num_valid), 32'd0);
      chk({tag, "_acc_count"}, 32'(bus.digit_count), 32'd0);
      chk({tag, "_acc_digits"}, 32'(bus.digits_bcd), 32'd0);
      chk({tag, "_acc_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_retain"}, 32'(bus.number), 32'(exp));
    end
  endtask

  task automatic expect_idle(input string tag, input int n);
    int highs;
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      if (bus.num_valid !== 1'b0 || bus.busy !== 1'b0) highs++;
    end
    chk({tag, "_idle"}, 32'(highs), 32'd0);
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    bus.scan_code  = 8'h00;
    bus.scan_valid = 1'b0;
    bus.num_ready  = 1'b0;
    reset          = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_number", 32'(bus.number), 32'd0);
    chk("rst_valid", 32'(bus.num_valid), 32'd0);
    chk("rst_digits", 32'(bus.digits_bcd), 32'd0);
    chk("rst_count", 32'(bus.digit_count), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b0;

    // 123 with interleaved break codes
    send(8'h16); send(8'hF0); send(8'h16);
    send(8'h1E); send(8'hF0); send(8'h1E);
    send(8'h26); send(8'hF0); send(8'h26);
    chk("t1_count", 32'(bus.digit_count), 32'd3);
    chk("t1_digits", 32'(bus.digits_bcd), 32'h123);
    sb.push_back(123);
    send(8'h5A);
    expect_number("t1", 3);

    // buffer full: fifth digit rejected with a one-cycle overflow pulse
    send(8'h16); chk("t2_ovf1", 32'(bus.overflow), 32'd0);
    send(8'h1E); chk("t2_ovf2", 32'(bus.overflow), 32'd0);
    send(8'h26); chk("t2_ovf3", 32'(bus.overflow), 32'd0);
    send(8'h25); chk("t2_ovf4", 32'(bus.overflow), 32'd0);
    send(8'h2E); chk("t2_ovf5", 32'(bus.overflow), 32'd1);
    @(negedge CLOCK_50);
    chk("t2_ovf_end", 32'(bus.overflow), 32'd0);
    chk("t2_digits", 32'(bus.digits_bcd), 32'h1234);
    chk("t2_count", 32'(bus.digit_count), 32'd4);
    sb.push_back(1234);
    send(8'h5A);
    expect_number("t2", 4);

    // backspace
    send(8'h16); send(8'h1E); send(8'h66);
    chk("t3_bksp_count", 32'(bus.digit_count), 32'd1);
    chk("t3_bksp_digits", 32'(bus.digits_bcd), 32'h1);
    send(8'h26);
    sb.push_back(13);
    send(8'h5A);
    expect_number("t3", 2);

    // escape clears; Enter on empty buffer is ignored; backspace on empty is harmless
    send(8'h3D); send(8'h76);
    chk("t4_esc_count", 32'(bus.digit_count), 32'd0);
    chk("t4_esc_digits", 32'(bus.digits_bcd), 32'd0);
    send(8'h66);
    chk("t4_bksp0_count", 32'(bus.digit_count), 32'd0);
    send(8'h5A);
    expect_idle("t4", 6);

    // leading zero plus extended Enter
    send(8'h45); send(8'h46);
    chk("t5_digits", 32'(bus.digits_bcd), 32'h09);
    sb.push_back(9);
    send(8'hE0); send(8'h5A);
    expect_number("t5", 2);

    // extended break of Enter does nothing
    send(8'h16);
    send(8'hE0); send(8'hF0); send(8'h5A);
    expect_idle("t6", 6);
    chk("t6_count", 32'(bus.digit_count), 32'd1);
    send(8'h76);

    // keys during HOLD are dropped; a pending F0 survives acceptance
    send(8'h25);
    send(8'h5A);
    @(negedge CLOCK_50);
    chk("t7_hold_valid", 32'(bus.num_valid), 32'd1);
    chk("t7_hold_number", 32'(bus.number), 32'd4);
    send(8'h3D);
    chk("t7_drop_count", 32'(bus.digit_count), 32'd1);
    chk("t7_drop_digits", 32'(bus.digits_bcd), 32'h4);
    send(8'hF0);
    bus.num_ready = 1'b1;
    @(negedge CLOCK_50);
    bus.num_ready = 1'b0;
    chk("t7_acc_valid", 32'(bus.num_valid), 32'd0);
    send(8'h5A);
    expect_idle("t7", 6);
    chk("t7_count0", 32'(bus.digit_count), 32'd0);
    send(8'h3D);
    chk("t7_after_count", 32'(bus.digit_count), 32'd1);
    chk("t7_after_digits", 32'(bus.digits_bcd), 32'h7);
    send(8'h76);

    // reset mid-conversion aborts
    send(8'h3E); send(8'h3E); send(8'h3E); send(8'h3E);
    send(8'h5A);
    @(negedge CLOCK_50);
    chk("t8_busy_pre", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t8_rst_number", 32'(bus.number), 32'd0);
    chk("t8_rst_valid", 32'(bus.num_valid), 32'd0);
    chk("t8_rst_digits", 32'(bus.digits_bcd), 32'd0);
    chk("t8_rst_count", 32'(bus.digit_count), 32'd0);
    chk("t8_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    expect_idle("t8", 8);

    // same entry without reset
    send(8'h3E); send(8'h3E); send(8'h3E); send(8'h3E);
    sb.push_back(8888);
    send(8'h5A);
    expect_number("t9", 4);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
